alu_op_sequencer: RTL

Upstream issue stage for the ALU datapath. It accepts complete operation requests (operands, command, mode, carry-in, split policy) over a valid/ready interface and buffers them in a small FIFO. It drives the ALU input bus (INP_VALID, OPA, OPB, CMD, MODE, CIN, CE) one operation at a time, either as a single combined beat or as two operand halves separated by a programmable gap. After the ALU latency elapses it emits a one-cycle result strobe so the downstream capture stage knows when RES and the flags are valid.

---
 rtl/alu_seq_pkg.sv | 67 ++++++
 rtl/alu_seq_fifo.sv | 60 ++++++
 rtl/alu_op_sequencer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer.
package alu_seq_pkg;

    // ALU bus widths. The request struct is built from these, so the
    // sequencer's DW/CW parameters must stay equal to them.
    localparam int ALU_DW = 8;
    localparam int ALU_CW = 4;
    localparam int GAP_W  = 5;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        GAP    = 3'd2,
        SECOND = 3'd3,
        WAIT   = 3'd4,
        RESV   = 3'd5
    } state_t;

    // Operand split policy (2'b11 behaves like SPLIT_BOTH)
    localparam logic [1:0] SPLIT_BOTH = 2'b00;
    localparam logic [1:0] SPLIT_AB   = 2'b01;
    localparam logic [1:0] SPLIT_BA   = 2'b10;

    // ALU operand-valid codes
    localparam logic [1:0] IV_NONE = 2'b00;
    localparam logic [1:0] IV_A    = 2'b01;
    localparam logic [1:0] IV_B    = 2'b10;
    localparam logic [1:0] IV_AB   = 2'b11;

    // Arithmetic-mode commands that take the long ALU path
    localparam logic [ALU_CW-1:0] CMD_MUL_INC = 4'd9;
    localparam logic [ALU_CW-1:0] CMD_SHL_SUB = 4'd10;

    localparam int LAT_STD   = 1;
    localparam int LAT_MULTI = 3;
    localparam int LATE_GAP  = 16;

    // One complete operation request as stored in the FIFO
    typedef struct packed {
        logic [ALU_DW-1:0] opa;
        logic [ALU_DW-1:0] opb;
        logic [ALU_CW-1:0] cmd;
        logic              mode;
        logic              cin;
        logic [1:0]        split;
        logic [GAP_W-1:0]  gap;
    } req_t;

    // True when the operands go out as two separate beats
    function automatic logic is_split(input logic [1:0] s);
        return (s == SPLIT_AB) || (s == SPLIT_BA);
    endfunction

    // Starting value of the WAIT countdown (ALU latency minus one)
    function automatic logic [1:0] lat_m1(input req_t r);
        if (r.mode && ((r.cmd == CMD_MUL_INC) || (r.cmd == CMD_SHL_SUB)))
            return 2'(LAT_MULTI - 1);
        return 2'(LAT_STD - 1);
    endfunction

    // A long gap between halves trips the ALU's operand timeout
    function automatic logic is_late(input req_t r);
        return is_split(r.split) && (int'(r.gap) >= LATE_GAP);
    endfunction

endpackage

// File: rtl/alu_seq_fifo.sv
// Request FIFO: DEPTH entries, show-ahead read, occupancy counter for full/empty.
module alu_seq_fifo
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic push,
    input  logic pop,
    input  req_t din,
    output req_t dout,
    output logic full,
    output logic empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW = $clog2(DEPTH + 1);

    req_t          r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [NW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    // A push into a full FIFO or a pop from an empty one is dropped
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    assign full  = (r_count == NW'(DEPTH));
    assign empty = (r_count == '0);
    assign dout  = r_mem[r_rd_ptr];

    // Storage; contents are don't-care until written, so no reset
    always_ff @(posedge CLK) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= din;
    end

    // Pointers wrap naturally (power-of-two depth); count tracks occupancy
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + NW'(1);
                2'b01:   r_count <= r_count - NW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU issue stage: buffers requests, drives the ALU input bus one op at a
// time (single beat or two halves with a gap), then strobes res_valid once
// the ALU latency has elapsed.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DW    = ALU_DW,
    parameter int CW    = ALU_CW,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [DW-1:0]    req_opa,
    input  logic [DW-1:0]    req_opb,
    input  logic [CW-1:0]    req_cmd,
    input  logic             req_mode,
    input  logic             req_cin,
    input  logic [1:0]       req_split,
    input  logic [GAP_W-1:0] req_gap,
    output logic [1:0]       INP_VALID,
    output logic [DW-1:0]    OPA,
    output logic [DW-1:0]    OPB,
    output logic [CW-1:0]    CMD,
    output logic             MODE,
    output logic             CIN,
    output logic             CE,
    output logic             res_valid,
    output logic             late,
    output logic             busy
);

    req_t             w_din;
    req_t             w_dout;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;

    state_t           r_state;
    state_t           w_state_n;
    req_t             r_op;
    req_t             w_op_n;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [GAP_W-1:0] w_gap_cnt_n;
    logic [1:0]       r_lat_cnt;
    logic [1:0]       w_lat_cnt_n;
    logic             r_late_op;
    logic             w_late_op_n;

    logic [1:0]       r_inp_valid, w_inp_valid_n;
    logic [DW-1:0]    r_opa,       w_opa_n;
    logic [DW-1:0]    r_opb,       w_opb_n;
    logic [CW-1:0]    r_cmd,       w_cmd_n;
    logic             r_mode,      w_mode_n;
    logic             r_cin,       w_cin_n;
    logic             r_ce;
    logic             r_res_valid, w_res_valid_n;
    logic             r_late,      w_late_n;

    assign w_din.opa   = req_opa;
    assign w_din.opb   = req_opb;
    assign w_din.cmd   = req_cmd;
    assign w_din.mode  = req_mode;
    assign w_din.cin   = req_cin;
    assign w_din.split = req_split;
    assign w_din.gap   = req_gap;

    assign w_push    = req_valid && !w_full;
    assign req_ready = !w_full;
    assign busy      = (r_state != IDLE) || !w_empty;

    alu_seq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_din),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    // Next state, op register load and beat/latency counters
    always_comb begin
        w_state_n   = r_state;
        w_op_n      = r_op;
        w_pop       = 1'b0;
        w_gap_cnt_n = r_gap_cnt;
        w_lat_cnt_n = r_lat_cnt;
        w_late_op_n = r_late_op;
        unique case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_op_n      = w_dout;
                    w_late_op_n = is_late(w_dout);
                    w_state_n   = ISSUE;
                end
            end
            ISSUE: begin
                if (is_split(r_op.split)) begin
                    w_gap_cnt_n = r_op.gap;
                    w_state_n   = (r_op.gap == '0) ? SECOND : GAP;
                end else begin
                    w_lat_cnt_n = lat_m1(r_op);
                    w_state_n   = WAIT;
                end
            end
            GAP: begin
                // Loaded with req_gap, so GAP lasts exactly req_gap cycles
                w_gap_cnt_n = r_gap_cnt - GAP_W'(1);
                if (r_gap_cnt <= GAP_W'(1))
                    w_state_n = SECOND;
            end
            SECOND: begin
                w_lat_cnt_n = lat_m1(r_op);
                w_state_n   = WAIT;
            end
            WAIT: begin
                if (r_lat_cnt == 2'd0)
                    w_state_n = RESV;
                else
                    w_lat_cnt_n = r_lat_cnt - 2'd1;
            end
            RESV: begin
                // Chain straight into the next op to avoid an IDLE bubble
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_op_n      = w_dout;
                    w_late_op_n = is_late(w_dout);
                    w_state_n   = ISSUE;
                end else begin
                    w_state_n = IDLE;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    // ALU bus values for the state being entered, so they can be registered
    always_comb begin
        w_inp_valid_n = IV_NONE;
        w_opa_n       = '0;
        w_opb_n       = '0;
        w_cmd_n       = '0;
        w_mode_n      = 1'b0;
        w_cin_n       = 1'b0;
        w_res_valid_n = 1'b0;
        w_late_n      = 1'b0;
        if (w_state_n inside {ISSUE, GAP, SECOND, WAIT}) begin
            w_cmd_n  = w_op_n.cmd;
            w_mode_n = w_op_n.mode;
            w_cin_n  = w_op_n.cin;
        end
        unique case (w_state_n)
            ISSUE: begin
                case (w_op_n.split)
                    SPLIT_AB: begin
                        w_inp_valid_n = IV_A;
                        w_opa_n       = w_op_n.opa;
                    end
                    SPLIT_BA: begin
                        w_inp_valid_n = IV_B;
                        w_opb_n       = w_op_n.opb;
                    end
                    default: begin
                        w_inp_valid_n = IV_AB;
                        w_opa_n       = w_op_n.opa;
                        w_opb_n       = w_op_n.opb;
                    end
                endcase
            end
            SECOND: begin
                // Only split ops get here: send whichever half is still missing
                if (w_op_n.split == SPLIT_AB) begin
                    w_inp_valid_n = IV_B;
                    w_opb_n       = w_op_n.opb;
                end else begin
                    w_inp_valid_n = IV_A;
                    w_opa_n       = w_op_n.opa;
                end
            end
            RESV: begin
                w_res_valid_n = 1'b1;
                w_late_n      = w_late_op_n;
            end
            default: ;
        endcase
    end

    // State, op context and registered ALU-side outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= IDLE;
            r_op        <= '0;
            r_gap_cnt   <= '0;
            r_lat_cnt   <= '0;
            r_late_op   <= 1'b0;
            r_inp_valid <= IV_NONE;
            r_opa       <= '0;
            r_opb       <= '0;
            r_cmd       <= '0;
            r_mode      <= 1'b0;
            r_cin       <= 1'b0;
            r_ce        <= 1'b0;
            r_res_valid <= 1'b0;
            r_late      <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_op        <= w_op_n;
            r_gap_cnt   <= w_gap_cnt_n;
            r_lat_cnt   <= w_lat_cnt_n;
            r_late_op   <= w_late_op_n;
            r_inp_valid <= w_inp_valid_n;
            r_opa       <= w_opa_n;
            r_opb       <= w_opb_n;
            r_cmd       <= w_cmd_n;
            r_mode      <= w_mode_n;
            r_cin       <= w_cin_n;
            r_ce        <= 1'b1;
            r_res_valid <= w_res_valid_n;
            r_late      <= w_late_n;
        end
    end

    assign INP_VALID = r_inp_valid;
    assign OPA       = r_opa;
    assign OPB       = r_opb;
    assign CMD       = r_cmd;
    assign MODE      = r_mode;
    assign CIN       = r_cin;
    assign CE        = r_ce;
    assign res_valid = r_res_valid;
    assign late      = r_late;

endmodule
